// File: rtl/spi_sensor_pkg.sv
// Shared constants, FSM state type and frame formatting for the SPI sensor responder.
// Optional frame checking is enabled by defining SPI_SLAVE_FRAME_CHK_EN.
package spi_sensor_pkg;

    localparam int WORD_BITS   = 16;
    localparam int DATA_BITS   = 8;
    localparam int LEAD_ZEROS  = 4;
    localparam int CNT_W       = $clog2(WORD_BITS + 1);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } state_e;

    // Sample sits below LEAD_ZEROS zero bits; the remaining low bits stay zero.
    function automatic logic [WORD_BITS-1:0] build_word(input logic [DATA_BITS-1:0] sample);
        logic [WORD_BITS-1:0] w;
        w = '0;
        w[WORD_BITS-1-LEAD_ZEROS -: DATA_BITS] = sample;
        return w;
    endfunction

endpackage

// File: rtl/spi_sensor_slave_if.sv
// SPI link plus sample handshake between the sensor responder and its surroundings.
interface spi_sensor_slave_if;
    import spi_sensor_pkg::*;

    logic                 SCLK;
    logic                 SS;
    logic                 MISO;
    logic [DATA_BITS-1:0] sample_in;
    logic                 sample_valid;
    logic                 sample_ready;

    modport slave (
        input  SCLK, SS, sample_in, sample_valid,
        output MISO, sample_ready
    );

    modport master (
        output SCLK, SS, sample_in, sample_valid,
        input  MISO, sample_ready
    );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-stage synchronizer for an asynchronous input with rise/fall pulses on the synced copy.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_sensor_slave.sv
// SPI responder returning {4'b0, sample, 4'b0} MSB first for every SS-low frame.
// Define SPI_SLAVE_FRAME_CHK_EN for the short-frame pulse and the completed-frame counter.
module spi_sensor_slave
    import spi_sensor_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    spi_sensor_slave_if.slave       bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_short
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (bus.SCLK),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk     (clk),
        .reset   (reset),
        .d_i     (bus.SS),
        .level_o (ss_level),
        .rise_o  (ss_rise),
        .fall_o  (ss_fall)
    );

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 miso_q, miso_d;
    logic                 frame_done_q, frame_done_d;
    logic [DATA_BITS-1:0] hold_q, cur_q;
    logic                 hold_full_q;
    logic                 accept, consume;
    logic [DATA_BITS-1:0] next_sample;
    logic [WORD_BITS-1:0] next_word;

`ifdef SPI_SLAVE_FRAME_CHK_EN
    logic       short_q, short_d;
    logic [7:0] frame_cnt_q;
`endif

    assign accept      = bus.sample_valid & ~hold_full_q;
    // Without a fresh sample the previous one is sent again.
    assign next_sample = hold_full_q ? hold_q : cur_q;
    assign next_word   = build_word(next_sample);

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        frame_done_d = 1'b0;
        consume      = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHK_EN
        short_d      = 1'b0;
`endif
        case (state_q)
            WAIT_IDLE: begin
                miso_d = 1'b0;
                if (ss_level) state_d = IDLE;
            end
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    consume   = 1'b1;
                    shreg_d   = next_word;
                    bit_cnt_d = '0;
                    miso_d    = next_word[WORD_BITS-1];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // SS edges take priority over any SCLK edge seen in the same cycle.
                if (ss_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        frame_done_d = 1'b1;
                    end else begin
`ifdef SPI_SLAVE_FRAME_CHK_EN
                        short_d = 1'b1;
`endif
                    end
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    if (bit_cnt_q != CNT_FULL) bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt_q >= CNT_FULL) begin
                        miso_d = 1'b0;
                    end else if (bit_cnt_q != '0) begin
                        shreg_d = shreg_q << 1;
                        miso_d  = shreg_q[WORD_BITS-2];
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= WAIT_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            frame_done_q <= 1'b0;
            hold_q       <= '0;
            cur_q        <= '0;
            hold_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            frame_done_q <= frame_done_d;
            if (accept) hold_q <= bus.sample_in;
            if (consume) cur_q <= next_sample;
            hold_full_q  <= accept | (hold_full_q & ~consume);
        end
    end

`ifdef SPI_SLAVE_FRAME_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            short_q     <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            short_q <= short_d;
            if (frame_done_q) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end
    assign err_short = short_q;
`else
    assign err_short = 1'b0;
`endif

    assign bus.MISO         = miso_q;
    assign bus.sample_ready = ~hold_full_q;
    assign busy             = (state_q == SHIFT);
    assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Directed and randomized checks of spi_sensor_slave against a word-level reference model.
module tb_spi_sensor_slave;

    logic clk = 1'b0;
    logic reset;
    logic busy, frame_done, err_short;

    spi_sensor_slave_if bus_if ();

    spi_sensor_slave dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .busy       (busy),
        .frame_done (frame_done),
        .err_short  (err_short)
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;
    int fd_cnt = 0;
    int es_cnt = 0;

    // Reference model: one-deep holding slot, last sent sample, completed frames.
    logic       m_full;
    logic [7:0] m_hold;
    logic [7:0] m_cur;
    int         m_frames;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (err_short)  es_cnt++;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] s);
        return 32'(s) * 32'd16;
    endfunction

    task automatic offer(input logic [7:0] v);
        @(negedge clk);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_in    = v;
        check("ready_at_offer", 32'(bus_if.sample_ready), 32'(!m_full));
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = v;
        end
    endtask

    // Master side of one frame; word collects the first 16 bits, extra_nz flags any 1 after them.
    task automatic spi_frame(input int n_sclk, input int hp,
                             output logic [31:0] word, output logic extra_nz);
        word = '0;
        extra_nz = 1'b0;
        @(negedge clk);
        bus_if.SS = 1'b0;
        if (m_full) begin
            m_cur  = m_hold;
            m_full = 1'b0;
        end
        repeat (hp * 2) @(negedge clk);
        for (int i = 0; i < n_sclk; i++) begin
            bus_if.SCLK = 1'b0;
            repeat (hp) @(negedge clk);
            bus_if.SCLK = 1'b1;
            if (i < 16) word = {word[30:0], bus_if.MISO};
            else if (bus_if.MISO) extra_nz = 1'b1;
            repeat (hp) @(negedge clk);
        end
        repeat (hp) @(negedge clk);
        bus_if.SS = 1'b1;
        if (n_sclk >= 16) m_frames++;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_cnt(input string tag);
`ifdef SPI_SLAVE_FRAME_CHK_EN
        check(tag, 32'(dut.frame_cnt_q), 32'(m_frames % 256));
`else
        check(tag, 32'(err_short), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] w;
        logic        xnz;
        int          fd0, es0, exp_es;
        logic [7:0]  s;

        m_full = 1'b0; m_hold = '0; m_cur = '0; m_frames = 0;
        reset = 1'b0;
        bus_if.SCLK = 1'b1;
        bus_if.SS = 1'b1;
        bus_if.sample_valid = 1'b0;
        bus_if.sample_in = '0;
`ifdef SPI_SLAVE_FRAME_CHK_EN
        exp_es = 1;
`else
        exp_es = 0;
`endif
        repeat (4) @(negedge clk);
        check("reset_miso", 32'(bus_if.MISO), 32'd0);
        check("reset_ready", 32'(bus_if.sample_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_err_short", 32'(err_short), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // 1) basic frame
        offer(8'hA5);
        check("t1_ready_low", 32'(bus_if.sample_ready), 32'd0);
        fd0 = fd_cnt;
        spi_frame(16, 8, w, xnz);
        check("t1_word", w, exp_word(m_cur));
        check("t1_word_const", w, 32'h0A50);
        check("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        check_cnt("t1_cnt");

        // 2) resend without a new sample
        offer(8'h3C);
        spi_frame(16, 8, w, xnz);
        check("t2_word1", w, exp_word(m_cur));
        spi_frame(16, 6, w, xnz);
        check("t2_word2", w, 32'h03C0);
        check("t2_ready", 32'(bus_if.sample_ready), 32'd1);

        // 3) valid held across two values: only the first is taken
        @(negedge clk);
        bus_if.sample_valid = 1'b1;
        bus_if.sample_in = 8'h11;
        m_full = 1'b1; m_hold = 8'h11;
        @(negedge clk);
        bus_if.sample_in = 8'h22;
        check("t3_ready_drop", 32'(bus_if.sample_ready), 32'd0);
        repeat (2) @(negedge clk);
        bus_if.sample_valid = 1'b0;
        spi_frame(16, 8, w, xnz);
        check("t3_word", w, exp_word(m_cur));
        check("t3_word_const", w, 32'h0110);
        check("t3_ready_back", 32'(bus_if.sample_ready), 32'd1);

        // 4) short frame
        fd0 = fd_cnt; es0 = es_cnt;
        spi_frame(9, 8, w, xnz);
        check("t4_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("t4_err_short", 32'(es_cnt - es0), 32'(exp_es));
        offer(8'h5A);
        fd0 = fd_cnt;
        spi_frame(16, 8, w, xnz);
        check("t4_next_word", w, exp_word(m_cur));
        check("t4_next_done", 32'(fd_cnt - fd0), 32'd1);
        check_cnt("t4_cnt");

        // 5) reset in the middle of a frame
        offer(8'hF0);
        @(negedge clk);
        bus_if.SS = 1'b0;
        m_cur = m_hold; m_full = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_if.SCLK = 1'b0; repeat (8) @(negedge clk);
            bus_if.SCLK = 1'b1; repeat (8) @(negedge clk);
        end
        bus_if.SCLK = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_miso_pre_reset", 32'(bus_if.MISO), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_miso_async", 32'(bus_if.MISO), 32'd0);
        check("t5_busy_async", 32'(busy), 32'd0);
        m_full = 1'b0; m_hold = '0; m_cur = '0; m_frames = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        fd0 = fd_cnt;
        for (int i = 0; i < 6; i++) begin
            bus_if.SCLK = 1'b1; repeat (8) @(negedge clk);
            check("t5_silent_miso", 32'(bus_if.MISO), 32'd0);
            bus_if.SCLK = 1'b0; repeat (8) @(negedge clk);
            check("t5_silent_busy", 32'(busy), 32'd0);
        end
        bus_if.SCLK = 1'b1;
        repeat (8) @(negedge clk);
        bus_if.SS = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        s = 8'($urandom);
        offer(s);
        spi_frame(16, 8, w, xnz);
        check("t5_after_reset_word", w, exp_word(m_cur));
        check_cnt("t5_cnt");

        // 6) long frame clocks out trailing zeros
        offer(8'hFF);
        fd0 = fd_cnt;
        spi_frame(20, 5, w, xnz);
        check("t6_word", w, 32'h0FF0);
        check("t6_extra_zero", 32'(xnz), 32'd0);
        check("t6_frame_done", 32'(fd_cnt - fd0), 32'd1);

        // randomized samples, optional offers and SCLK rates
        for (int k = 0; k < 10; k++) begin
            s = 8'($urandom);
            if ($urandom_range(0, 1) == 1) offer(s);
            fd0 = fd_cnt;
            spi_frame(16 + int'($urandom_range(0, 3)), int'($urandom_range(4, 8)), w, xnz);
            check("rand_word", w, exp_word(m_cur));
            check("rand_extra", 32'(xnz), 32'd0);
            check("rand_done", 32'(fd_cnt - fd0), 32'd1);
        end
        check_cnt("rand_cnt");

`ifdef SPI_SLAVE_FRAME_CHK_EN
        while ((m_frames % 256) != 255) spi_frame(16, 4, w, xnz);
        check_cnt("wrap_255");
        offer(8'hFF);
        spi_frame(20, 4, w, xnz);
        check("wrap_word", w, 32'h0FF0);
        check_cnt("wrap_0");
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
